mem_io_ctrl: RTL
================

// Module: mem_io_ctrl
// PURPOSE
//  Address control and memory-access sequencer for the LC-3 datapath. One access at a time comes from the control FSM (MIO_EN, R_W, MAR, MDR).
//  Decodes device space (KBSR/KBDR/DSR/DDR, opt. MCR) vs. RAM, drives MIOMUX select and device load strobes.
//  Runs a req/ack handshake with RAM, with timeout, and returns a one-cycle ready (R) to the control FSM.
// PARAMETERS
//  TIMEOUT_CYC  15  max cycles o_MEM_REQ waits for i_MEM_ACK before bus error (1..255)
//  CNT_W        8   width of timeout counter; must hold TIMEOUT_CYC
// PORTS
//  i_Clk        in   1   system clock, all state on rising edge
//  i_Rst        in   1   asynchronous, active-high reset
//  i_MIO_EN     in   1   access request; held high by FSM until o_R
//  i_R_W        in   1   1=write, 0=read; sampled at accept
//  i_MAR        in   16  access address; sampled at accept
//  i_KB_RDY     in   1   keyboard has a char (drives KBSR[15])
//  i_DS_RDY     in   1   display ready (drives DSR[15])
//  i_MEM_ACK    in   1   RAM completed access (one-cycle pulse)
//  o_MEM_REQ    out  1   RAM request, held until ack/timeout
//  o_MEM_WE     out  1   RAM write enable, valid with o_MEM_REQ
//  o_MIOMUX_SEL out  2   0=RAM 1=KBSR 2=KBDR 3=DSR (MDR source on reads)
//  o_LD_MDR     out  1   one-cycle MDR load strobe for reads
//  o_LD_KBSR    out  1   one-cycle strobe, write to KBSR
//  o_LD_DSR     out  1   one-cycle strobe, write to DSR
//  o_LD_DDR     out  1   one-cycle strobe, write to DDR
//  o_KBDR_RD    out  1   one-cycle pulse on KBDR read (clears keyboard ready)
//  o_R          out  1   one-cycle access-complete pulse
//  o_BUS_ERR    out  1   sticky; set on RAM timeout, cleared by next accept
// BEHAVIOUR
//  - Reset (async, any state): FSM->IDLE, counter 0, latches 0. All outputs 0, incl. o_BUS_ERR.
//  - FSM: IDLE, DEV, MEM, DONE.
//  - IDLE: if i_MIO_EN=1, accept: latch MAR and R_W, clear o_BUS_ERR, decode.
//    Device address -> DEV. Otherwise -> MEM.
//  - Device map: xFE00 KBSR, xFE02 KBDR, xFE04 DSR, xFE06 DDR, xFFFE MCR (MCR_EN only).
//    Unmapped xFE00-xFFFF goes to RAM.
//  - DEV (1 cycle): read sets o_MIOMUX_SEL and pulses o_LD_MDR; KBDR read also pulses o_KBDR_RD.
//    Write pulses the matching o_LD_*; writes to KBDR are ignored. -> DONE.
//  - MEM: o_MEM_REQ=1, o_MEM_WE=latched R_W, counter increments every cycle.
//    i_MEM_ACK -> drop req; on read pulse o_LD_MDR (SEL=0) same cycle; -> DONE.
//    counter==TIMEOUT_CYC with no ack -> drop req, set o_BUS_ERR, no MDR load, -> DONE.
//    Ack arriving on the timeout cycle counts as success.
//  - DONE: o_R=1 for one cycle -> IDLE. New accept is possible the cycle after DONE.
//  - Latency: device access o_R at accept+2. RAM access o_R at ack+1.
//  - Abort: i_MIO_EN low in DEV/MEM -> IDLE next cycle, no o_R, req dropped, no strobes after the drop.
//  - i_MAR/i_R_W changes after accept are ignored. i_MEM_ACK in IDLE/DEV/DONE is ignored.
//  - o_MIOMUX_SEL holds its last value outside strobe cycles.
// CONFIGURATION
//  - MCR_EN defined: adds output o_CLK_EN (1 bit, reset 1) for Machine Control Register xFFFE.
//    Write: o_CLK_EN <= i_MDR_BIT15 (extra 1-bit input, sampled in DEV). Read: o_MIOMUX_SEL=2'b00 with RAM bypassed, MDR[15]=o_CLK_EN via extra output o_MCR_RD (1-cycle pulse).
//    o_CLK_EN=0 halts the control FSM externally.
//  - MCR_EN undefined: xFFFE is plain RAM; o_CLK_EN, o_MCR_RD and i_MDR_BIT15 are absent.
// STRUCTURE
//  - Package mem_io_pkg: device address constants (ADDR_KBSR/KBDR/DSR/DDR/MCR), FSM state enum, MIOMUX select encodings.
//  - Sub-module io_addr_decode: combinational MAR -> {is_dev, dev_id}. Shared with future interrupt logic.
//  - Sequencer, counter and strobes live in the top module.
// TESTING
//  1. Reset mid-MEM: assert i_Rst with o_MEM_REQ=1 -> all outputs 0 at once, FSM idle, next access starts normally.
//  2. Read x3000, ack 3 cycles after req -> o_LD_MDR with SEL=0 on ack cycle, o_R next cycle, o_MEM_WE=0 throughout.
//  3. Read xFE02 -> o_LD_MDR and o_KBDR_RD at accept+1, SEL=2, o_R at accept+2, o_MEM_REQ never asserted.
//  4. Write xFE06, then write xFE02 -> o_LD_DDR pulses once. KBDR write: no strobes, o_R still pulses.
//  5. Write x4000, no ack (TIMEOUT_CYC=15) -> req held 15 cycles, o_BUS_ERR=1, o_R pulse, no o_LD_MDR. Next accept clears o_BUS_ERR.
//  6. MIO_EN dropped 2 cycles into MEM -> req low next cycle, no o_R. Ack on the timeout boundary -> success, no error.
//  (MCR_EN build) write xFFFE with bit15=0 -> o_CLK_EN=0, RAM untouched.

Source files
------------

// File: rtl/mem_io_pkg.sv
// rtl/mem_io_pkg.sv - LC-3 memory/IO controller: device addresses, FSM states, MIOMUX select codes
package mem_io_pkg;
   localparam logic [15:0] ADDR_KBSR = 16'hFE00;
   localparam logic [15:0] ADDR_KBDR = 16'hFE02;
   localparam logic [15:0] ADDR_DSR  = 16'hFE04;
   localparam logic [15:0] ADDR_DDR  = 16'hFE06;
   localparam logic [15:0] ADDR_MCR  = 16'hFFFE;

   typedef enum logic [1:0] {ST_IDLE, ST_DEV, ST_MEM, ST_DONE} state_t;
   typedef enum logic [2:0] {DEV_NONE, DEV_KBSR, DEV_KBDR, DEV_DSR, DEV_DDR, DEV_MCR} dev_id_t;

   localparam logic [1:0] SEL_RAM  = 2'd0;
   localparam logic [1:0] SEL_KBSR = 2'd1;
   localparam logic [1:0] SEL_KBDR = 2'd2;
   localparam logic [1:0] SEL_DSR  = 2'd3;

   // MCR reads come through the RAM leg of the mux with RAM bypassed
   function automatic logic [1:0] dev_sel(input dev_id_t id);
      case (id)
         DEV_KBSR: return SEL_KBSR;
         DEV_KBDR: return SEL_KBDR;
         DEV_DSR:  return SEL_DSR;
         default:  return SEL_RAM;
      endcase
   endfunction
endpackage

// File: rtl/io_addr_decode.sv
// rtl/io_addr_decode.sv - MAR to device-register decode (MCR at xFFFE only when MCR_EN is defined)
module io_addr_decode
   import mem_io_pkg::*;
(
   input  logic [15:0] i_addr,
   output logic        o_is_dev,
   output dev_id_t     o_dev_id
);
   always_comb begin
      o_is_dev = 1'b1;
      o_dev_id = DEV_NONE;
      case (i_addr)
         ADDR_KBSR: o_dev_id = DEV_KBSR;
         ADDR_KBDR: o_dev_id = DEV_KBDR;
         ADDR_DSR:  o_dev_id = DEV_DSR;
         ADDR_DDR:  o_dev_id = DEV_DDR;
`ifdef MCR_EN
         ADDR_MCR:  o_dev_id = DEV_MCR;
`endif
         default:   o_is_dev = 1'b0;
      endcase
   end
endmodule

// File: rtl/mem_io_ctrl.sv
// rtl/mem_io_ctrl.sv - LC-3 memory access sequencer: device decode, RAM req/ack with timeout, R pulse
// Optional Machine Control Register (o_CLK_EN, o_MCR_RD, i_MDR_BIT15) enabled by MCR_EN.
module mem_io_ctrl
   import mem_io_pkg::*;
#(
   parameter int TIMEOUT_CYC = 15,
   parameter int CNT_W       = 8
) (
   input  logic        i_Clk,
   input  logic        i_Rst,
   input  logic        i_MIO_EN,
   input  logic        i_R_W,
   input  logic [15:0] i_MAR,
   input  logic        i_KB_RDY,
   input  logic        i_DS_RDY,
   input  logic        i_MEM_ACK,
`ifdef MCR_EN
   input  logic        i_MDR_BIT15,
   output logic        o_CLK_EN,
   output logic        o_MCR_RD,
`endif
   output logic        o_MEM_REQ,
   output logic        o_MEM_WE,
   output logic [1:0]  o_MIOMUX_SEL,
   output logic        o_LD_MDR,
   output logic        o_LD_KBSR,
   output logic        o_LD_DSR,
   output logic        o_LD_DDR,
   output logic        o_KBDR_RD,
   output logic        o_R,
   output logic        o_BUS_ERR
);
   localparam logic [CNT_W-1:0] TO_VAL = CNT_W'(TIMEOUT_CYC);

   state_t           r_state, w_next;
   logic [15:0]      r_mar;
   logic             r_rw;
   logic [CNT_W-1:0] r_cnt;
   logic [CNT_W-1:0] w_cnt_inc;
   logic             r_bus_err;
   logic [1:0]       r_sel, w_sel;
   logic             w_accept, w_timeout, w_ld_mdr;
   logic             w_is_dev;
   dev_id_t          w_dev_id;
   logic [15:0]      w_dec_addr;
   logic             w_unused_rdy;
`ifdef MCR_EN
   logic             r_clk_en;
   logic             w_mcr_wr, w_mcr_rd;
`endif

   // Ready flags reach MDR through the external MIOMUX, not through this block
   assign w_unused_rdy = i_KB_RDY ^ i_DS_RDY;

   assign w_dec_addr = (r_state == ST_IDLE) ? i_MAR : r_mar;
   assign w_cnt_inc  = r_cnt + 1'b1;

   io_addr_decode u_dec (
      .i_addr   (w_dec_addr),
      .o_is_dev (w_is_dev),
      .o_dev_id (w_dev_id)
   );

   always_comb begin
      w_next       = r_state;
      w_accept     = 1'b0;
      w_timeout    = 1'b0;
      w_ld_mdr     = 1'b0;
      w_sel        = r_sel;
      o_MEM_REQ    = 1'b0;
      o_MEM_WE     = 1'b0;
      o_LD_KBSR    = 1'b0;
      o_LD_DSR     = 1'b0;
      o_LD_DDR     = 1'b0;
      o_KBDR_RD    = 1'b0;
      o_R          = 1'b0;
`ifdef MCR_EN
      w_mcr_wr     = 1'b0;
      w_mcr_rd     = 1'b0;
`endif
      case (r_state)
         ST_IDLE: begin
            if (i_MIO_EN) begin
               w_accept = 1'b1;
               w_next   = w_is_dev ? ST_DEV : ST_MEM;
            end
         end
         ST_DEV: begin
            if (!i_MIO_EN) begin
               w_next = ST_IDLE;
            end else begin
               w_next = ST_DONE;
               if (r_rw) begin
                  case (w_dev_id)
                     DEV_KBSR: o_LD_KBSR = 1'b1;
                     DEV_DSR:  o_LD_DSR  = 1'b1;
                     DEV_DDR:  o_LD_DDR  = 1'b1;
`ifdef MCR_EN
                     DEV_MCR:  w_mcr_wr  = 1'b1;
`endif
                     default:  ;
                  endcase
               end else begin
                  w_ld_mdr  = 1'b1;
                  w_sel     = dev_sel(w_dev_id);
                  o_KBDR_RD = (w_dev_id == DEV_KBDR);
`ifdef MCR_EN
                  w_mcr_rd  = (w_dev_id == DEV_MCR);
`endif
               end
            end
         end
         ST_MEM: begin
            o_MEM_REQ = 1'b1;
            o_MEM_WE  = r_rw;
            if (!i_MIO_EN) begin
               w_next = ST_IDLE;
            end else if (i_MEM_ACK) begin
               w_next   = ST_DONE;
               w_ld_mdr = !r_rw;
               if (!r_rw) w_sel = SEL_RAM;
            end else if (w_cnt_inc == TO_VAL) begin
               w_next    = ST_DONE;
               w_timeout = 1'b1;
            end
         end
         ST_DONE: begin
            o_R    = 1'b1;
            w_next = ST_IDLE;
         end
         default: w_next = ST_IDLE;
      endcase
   end

   assign o_LD_MDR     = w_ld_mdr;
   assign o_MIOMUX_SEL = w_sel;
   assign o_BUS_ERR    = r_bus_err;

   always_ff @(posedge i_Clk or posedge i_Rst) begin
      if (i_Rst) begin
         r_state   <= ST_IDLE;
         r_mar     <= '0;
         r_rw      <= 1'b0;
         r_cnt     <= '0;
         r_bus_err <= 1'b0;
         r_sel     <= SEL_RAM;
      end else begin
         r_state <= w_next;
         if (w_accept) begin
            r_mar     <= i_MAR;
            r_rw      <= i_R_W;
            r_cnt     <= '0;
            r_bus_err <= 1'b0;
         end else if (r_state == ST_MEM) begin
            r_cnt <= w_cnt_inc;
         end
         if (w_timeout) r_bus_err <= 1'b1;
         if (w_ld_mdr)  r_sel     <= w_sel;
      end
   end

`ifdef MCR_EN
   always_ff @(posedge i_Clk or posedge i_Rst) begin
      if (i_Rst)         r_clk_en <= 1'b1;
      else if (w_mcr_wr) r_clk_en <= i_MDR_BIT15;
   end

   assign o_CLK_EN = r_clk_en;
   assign o_MCR_RD = w_mcr_rd;
`endif
endmodule
